// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and defaults for the VRAM arbiter
package vram_pkg;

  localparam int STARVE_DEFAULT = 4;

  typedef enum bit [1:0] {S_IDLE, S_M0, S_M1} state_t;

  // m0 wins unless m1 is also waiting and m0 has used up its fairness budget.
  function automatic state_t arb_pick(input logic m0_cyc, input logic m1_cyc,
                                      input logic starved);
    if (m0_cyc && (!m1_cyc || !starved)) return S_M0;
    if (m1_cyc) return S_M1;
    return S_IDLE;
  endfunction

endpackage

// File: rtl/if_wb.sv
// rtl/if_wb.sv - Wishbone bus bundle; dat_o carries write data, dat_i read data
interface if_wb #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [DWIDTH/8-1:0]   sel;
  logic [AWIDTH-1:0]     adr;
  logic [DWIDTH-1:0]     dat_o;
  logic [DWIDTH-1:0]     dat_i;
  logic                  ack;

  modport master (output cyc, stb, we, sel, adr, dat_o, input dat_i, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_o, output dat_i, ack);
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - two-master Wishbone arbiter for the shared video memory
// m0 (video fetch) has priority; m1 (CPU) is protected by a starvation counter.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int STARVE = STARVE_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_wb.slave        m0,
  if_wb.slave        m1,
  if_wb.master       s,
  output logic [1:0] grant
);

  localparam int CW = $clog2(STARVE + 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          starved;
  logic          own0;
  logic          own1;

  assign starved = (starve_cnt == CW'(STARVE));

  // A released owner is handed straight to the next requester, no idle bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = arb_pick(m0.cyc, m1.cyc, starved);
      S_M0:    if (!m0.cyc) state_nxt = arb_pick(1'b0, m1.cyc, starved);
      S_M1:    if (!m1.cyc) state_nxt = arb_pick(m0.cyc, 1'b0, starved);
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!m1.cyc || (state_nxt == S_M1 && state != S_M1))
        starve_cnt <= '0;
      else if (state_nxt == S_M0 && state != S_M0 && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign own0  = (state == S_M0);
  assign own1  = (state == S_M1);
  assign grant = {own1, own0};

  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.sel   = {(DWIDTH/8){1'b0}};
    s.adr   = {AWIDTH{1'b0}};
    s.dat_o = {DWIDTH{1'b0}};
    if (own0) begin
      s.cyc   = m0.cyc;
      s.stb   = m0.stb;
      s.we    = m0.we;
      s.sel   = m0.sel;
      s.adr   = m0.adr;
      s.dat_o = m0.dat_o;
    end else if (own1) begin
      s.cyc   = m1.cyc;
      s.stb   = m1.stb;
      s.we    = m1.we;
      s.sel   = m1.sel;
      s.adr   = m1.adr;
      s.dat_o = m1.dat_o;
    end
  end

  // Gating ack with the owner's cyc drops acks that land after an abort.
  assign m0.ack   = own0 & m0.cyc & s.ack;
  assign m1.ack   = own1 & m1.cyc & s.ack;
  assign m0.dat_i = own0 ? s.dat_i : {DWIDTH{1'b0}};
  assign m1.dat_i = own1 ? s.dat_i : {DWIDTH{1'b0}};

endmodule
